// File: rtl/if_fetch_if.sv
// Instruction-ROM bus between the fetch stage (master) and the ROM (slave).
// Latency: none, wires only. Backpressure: the request is held until rom_gnt_i; responses cannot be stalled.
// Ports: rom_req_o/rom_addr_o driven by fetch; rom_gnt_i/rom_rvalid_i/rom_rdata_i driven by the ROM.
interface if_fetch_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);
   logic              rom_req_o;
   logic [ADDR_W-1:0] rom_addr_o;
   logic              rom_gnt_i;
   logic              rom_rvalid_i;
   logic [INST_W-1:0] rom_rdata_i;

   modport master (
      output rom_req_o,
      output rom_addr_o,
      input  rom_gnt_i,
      input  rom_rvalid_i,
      input  rom_rdata_i
   );

   modport slave (
      input  rom_req_o,
      input  rom_addr_o,
      output rom_gnt_i,
      output rom_rvalid_i,
      output rom_rdata_i
   );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, fetches from the ROM one request at a time, and presents instructions to IF/ID.
// Latency: grant to if_valid is the ROM response latency + 1 cycle; sustained rate is at best 1 instruction per 2 cycles.
// Backpressure: stall_i holds the output slot; a one-entry skid buffer catches the in-flight response, and no new request is issued while it is full.
// Ports: clk, rst (async, active-low); stall_i, branch_flag_i/branch_target_i from decode;
//        rom (if_fetch_if.master) ROM request/grant/response bus; if_pc/if_inst/if_valid to the IF/ID register.
module if_fetch #(
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              branch_flag_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   if_fetch_if.master        rom,
   output logic [ADDR_W-1:0] if_pc,
   output logic [INST_W-1:0] if_inst,
   output logic              if_valid
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] req_addr;   // address of the outstanding request, captured at grant
   logic              req_q;
   logic              drop;       // the outstanding response belongs to a flushed path
   logic              skid_vld;
   logic [ADDR_W-1:0] skid_pc;
   logic [INST_W-1:0] skid_inst;

   logic              consume;
   logic              resp_in;
   logic              deliver;
   logic              gnt_ev;
   logic [ADDR_W-1:0] br_pc;

   assign consume = if_valid & ~stall_i;
   // Responses only count while a request is outstanding; anything else is a leftover from before reset.
   assign resp_in = (state == WAIT) & rom.rom_rvalid_i;
   assign deliver = resp_in & ~drop;
   assign gnt_ev  = (state == REQ) & rom.rom_gnt_i;
   assign br_pc   = branch_target_i & ~ADDR_W'(3);

   assign rom.rom_req_o  = req_q;
   assign rom.rom_addr_o = pc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         req_q     <= 1'b0;
         req_addr  <= '0;
         drop      <= 1'b0;
         skid_vld  <= 1'b0;
         skid_pc   <= '0;
         skid_inst <= '0;
         if_valid  <= 1'b0;
         if_pc     <= '0;
         if_inst   <= '0;
      end else if (branch_flag_i) begin
         // Redirect wins over everything, including stall: flush slot and skid, restart at the target.
         if_valid <= 1'b0;
         if_inst  <= '0;
         skid_vld <= 1'b0;
         pc       <= br_pc;
         if (((state == WAIT) && !rom.rom_rvalid_i) || gnt_ev) begin
            // A request is still in flight. Keep a single request outstanding:
            // swallow its response first, then request the target.
            drop  <= 1'b1;
            state <= WAIT;
            req_q <= 1'b0;
         end else begin
            drop  <= 1'b0;
            state <= REQ;
            req_q <= 1'b1;
         end
      end else begin
         case (state)
            IDLE: begin
               state <= REQ;
               req_q <= 1'b1;
            end
            REQ: begin
               if (rom.rom_gnt_i) begin
                  req_addr <= pc;
                  pc       <= pc + ADDR_W'(4);
                  state    <= WAIT;
                  req_q    <= 1'b0;
               end
            end
            WAIT: begin
               if (rom.rom_rvalid_i) begin
                  if (drop) begin
                     drop  <= 1'b0;
                     state <= REQ;
                     req_q <= 1'b1;
                  end else if (!if_valid || consume) begin
                     // Response goes straight to the slot, skid stays empty.
                     state <= REQ;
                     req_q <= 1'b1;
                  end else begin
                     state <= HOLD;
                  end
               end
            end
            HOLD: begin
               // Skid is full here; it drains on the first consume.
               if (consume) begin
                  state <= REQ;
                  req_q <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               req_q <= 1'b0;
            end
         endcase

         // Output slot. The skid is only full in HOLD, when no response can arrive,
         // so the skid and the response never compete for the slot.
         if (skid_vld && consume) begin
            if_pc    <= skid_pc;
            if_inst  <= skid_inst;
            if_valid <= 1'b1;
            skid_vld <= 1'b0;
         end else if (deliver) begin
            if (!if_valid || consume) begin
               if_pc    <= req_addr;
               if_inst  <= rom.rom_rdata_i;
               if_valid <= 1'b1;
            end else begin
               skid_pc   <= req_addr;
               skid_inst <= rom.rom_rdata_i;
               skid_vld  <= 1'b1;
            end
         end else if (consume) begin
            if_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed steps followed by a randomized phase, all in one stimulus block.
// A ROM responder returns a fixed function of the address after a chosen latency.
// A stream model checks every consumed instruction: the addresses run sequentially from reset or from the last redirect.
module tb_if_fetch;

   logic        clk;
   logic        rst;
   logic        stall_i;
   logic        branch_flag_i;
   logic [31:0] branch_target_i;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_valid;

   int checks   = 0;
   int failures = 0;
   int consumed = 0;
   int lat      = 1;
   bit lat_rand = 0;
   bit gnt_rand = 0;

   if_fetch_if #(.ADDR_W(32), .INST_W(32)) rom_bus ();

   if_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall_i),
      .branch_flag_i   (branch_flag_i),
      .branch_target_i (branch_target_i),
      .rom             (rom_bus),
      .if_pc           (if_pc),
      .if_inst         (if_inst),
      .if_valid        (if_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] rom_fn(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_req(input string tag, input logic [31:0] exp_addr);
      int n = 0;
      while (rom_bus.rom_req_o !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_seen"}, 32'(rom_bus.rom_req_o), 32'd1);
      chk(tag, rom_bus.rom_addr_o, exp_addr);
   endtask

   task automatic wait_req_low();
      int n = 0;
      while (rom_bus.rom_req_o !== 1'b0 && n < 40) begin
         tick();
         n++;
      end
      chk("req_drop_seen", 32'(rom_bus.rom_req_o), 32'd0);
   endtask

   task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
      int n = 0;
      while (if_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, 32'(if_valid), 32'd1);
      chk({tag, "_pc"}, if_pc, exp_pc);
      chk({tag, "_inst"}, if_inst, rom_fn(exp_pc));
   endtask

   // ROM responder: one response per grant, after 'lat' cycles (or a random latency).
   initial begin : rom_model
      logic        hs;
      logic [31:0] haddr;
      logic        pend;
      logic [31:0] paddr;
      int          cnt;
      pend = 1'b0;
      paddr = '0;
      cnt = 0;
      rom_bus.rom_gnt_i    = 1'b1;
      rom_bus.rom_rvalid_i = 1'b0;
      rom_bus.rom_rdata_i  = '0;
      forever begin
         @(negedge clk);
         hs    = rst && rom_bus.rom_req_o && rom_bus.rom_gnt_i;
         haddr = rom_bus.rom_addr_o;
         @(posedge clk);
         #1;
         if (hs) begin
            chk("one_outstanding", 32'(pend), 32'd0);
            pend  = 1'b1;
            paddr = haddr;
            cnt   = lat_rand ? int'($urandom_range(1, 4)) : lat;
         end
         rom_bus.rom_rvalid_i = 1'b0;
         if (pend) begin
            if (cnt <= 1) begin
               rom_bus.rom_rvalid_i = 1'b1;
               rom_bus.rom_rdata_i  = rom_fn(paddr);
               pend = 1'b0;
            end else begin
               cnt--;
            end
         end
         rom_bus.rom_gnt_i = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   // Stream model: what the decode stage should see, edge by edge.
   initial begin : stream_model
      logic [31:0] exp_pc;
      logic        s_rst, s_v, s_st, s_br;
      logic [31:0] s_pc, s_inst, s_tg;
      exp_pc = 32'h0000_0000;
      forever begin
         @(negedge clk);
         s_rst  = rst;
         s_v    = if_valid;
         s_pc   = if_pc;
         s_inst = if_inst;
         s_st   = stall_i;
         s_br   = branch_flag_i;
         s_tg   = branch_target_i;
         @(posedge clk);
         if (!s_rst || !rst) begin
            exp_pc = 32'h0000_0000;
         end else if (s_br) begin
            exp_pc = {s_tg[31:2], 2'b00};
         end else if (s_v && !s_st) begin
            chk("stream_pc", s_pc, exp_pc);
            chk("stream_inst", s_inst, rom_fn(exp_pc));
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
      end
   end

   initial begin : stim
      int c0;
      rst = 1'b0;
      stall_i = 1'b0;
      branch_flag_i = 1'b0;
      branch_target_i = '0;
      #1;
      chk("rst_req", 32'(rom_bus.rom_req_o), 32'd0);
      chk("rst_addr", rom_bus.rom_addr_o, 32'h0);
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_pc", if_pc, 32'h0);
      chk("rst_inst", if_inst, 32'h0);

      // Back-to-back fetch, grant with request, response one cycle later.
      tick(); tick();
      rst = 1'b1;
      tick();
      chk("t1_req0", 32'(rom_bus.rom_req_o), 32'd1);
      chk("t1_addr0", rom_bus.rom_addr_o, 32'h0);
      chk("t1_valid_lo", 32'(if_valid), 32'd0);
      tick();
      chk("t1_wait_noreq", 32'(rom_bus.rom_req_o), 32'd0);
      tick();
      chk("t1_valid0", 32'(if_valid), 32'd1);
      chk("t1_pc0", if_pc, 32'h0);
      chk("t1_inst0", if_inst, rom_fn(32'h0));
      chk("t1_addr4", rom_bus.rom_addr_o, 32'h4);
      tick();
      chk("t1_valid_gap", 32'(if_valid), 32'd0);
      tick();
      chk("t1_pc4", if_pc, 32'h4);
      chk("t1_inst4", if_inst, rom_fn(32'h4));
      chk("t1_addr8", rom_bus.rom_addr_o, 32'h8);

      // Stall with skid capture.
      rst = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick(); tick(); tick();
      chk("st_pc0", if_pc, 32'h0);
      stall_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("st_hold_pc", if_pc, 32'h0);
         chk("st_hold_valid", 32'(if_valid), 32'd1);
         chk("st_no_req", 32'(rom_bus.rom_req_o), 32'd0);
      end
      stall_i = 1'b0;
      tick();
      chk("st_rel_pc4", if_pc, 32'h4);
      chk("st_rel_inst4", if_inst, rom_fn(32'h4));
      chk("st_rel_req", 32'(rom_bus.rom_req_o), 32'd1);
      chk("st_rel_addr8", rom_bus.rom_addr_o, 32'h8);

      // Redirect while waiting on pc=8.
      lat = 2;
      tick();
      branch_flag_i = 1'b1;
      branch_target_i = 32'h0000_0103;
      tick();
      branch_flag_i = 1'b0;
      chk("br_valid_lo", 32'(if_valid), 32'd0);
      tick();
      chk("br_drop_valid_lo", 32'(if_valid), 32'd0);
      wait_req("br_addr", 32'h0000_0100);
      wait_valid("br_tgt", 32'h0000_0100);

      // Redirect in the same cycle as a response, slot stalled.
      lat = 1;
      stall_i = 1'b1;
      c0 = 0;
      while (rom_bus.rom_rvalid_i !== 1'b1 && c0 < 20) begin
         tick();
         c0++;
      end
      branch_flag_i = 1'b1;
      branch_target_i = 32'h0000_2000;
      tick();
      branch_flag_i = 1'b0;
      stall_i = 1'b0;
      chk("brrv_valid", 32'(if_valid), 32'd0);
      chk("brrv_inst", if_inst, 32'h0);
      chk("brrv_req", 32'(rom_bus.rom_req_o), 32'd1);
      chk("brrv_addr", rom_bus.rom_addr_o, 32'h0000_2000);
      wait_valid("brrv_tgt", 32'h0000_2000);

      // PC wrap.
      stall_i = 1'b1;
      branch_flag_i = 1'b1;
      branch_target_i = 32'hFFFF_FFFC;
      tick();
      branch_flag_i = 1'b0;
      stall_i = 1'b0;
      wait_req("wrap_top", 32'hFFFF_FFFC);
      wait_req_low();
      wait_req("wrap_zero", 32'h0000_0000);

      // Async reset mid-WAIT, with the response landing during reset.
      lat = 3;
      wait_req_low();
      wait_req("ar_pre", rom_bus.rom_addr_o);
      tick();
      rst = 1'b0;
      #1;
      chk("ar_req", 32'(rom_bus.rom_req_o), 32'd0);
      chk("ar_addr", rom_bus.rom_addr_o, 32'h0);
      chk("ar_valid", 32'(if_valid), 32'd0);
      chk("ar_pc", if_pc, 32'h0);
      chk("ar_inst", if_inst, 32'h0);
      repeat (4) tick();
      rst = 1'b1;
      wait_req("ar_first", 32'h0000_0000);
      wait_valid("ar_first", 32'h0000_0000);

      // Randomized traffic: random grants, latencies, stalls and redirects.
      lat_rand = 1'b1;
      gnt_rand = 1'b1;
      c0 = consumed;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 31) == 0) begin
            branch_flag_i = 1'b1;
            stall_i = 1'b1;
            branch_target_i = ($urandom_range(0, 3) == 0) ?
                              (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         end else begin
            branch_flag_i = 1'b0;
            stall_i = ($urandom_range(0, 2) == 0);
         end
         tick();
      end
      branch_flag_i = 1'b0;
      stall_i = 1'b0;
      repeat (20) tick();
      chk("rand_progress", 32'((consumed - c0) > 100), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
